// File: rtl/range_pkg.sv
// Shared types and default sizing for the range-finding sample streamer.
// The chip top imports the same defaults so both sides agree on sample shape.
package range_pkg;

   localparam int RANGE_WIDTH = 16;
   localparam int RANGE_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } state_t;

endpackage

// File: rtl/range_sample_buffer.sv
// Sample storage: synchronous write port, asynchronous read port.
// The data array is deliberately left without reset.
module range_sample_buffer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/range_streamer.sv
// Buffers host samples and replays them as one go/finish/data transaction
// towards the range-finding block.
module range_streamer
   import range_pkg::*;
#(
   parameter int WIDTH = RANGE_WIDTH,
   parameter int DEPTH = RANGE_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             start,
   input  logic             abort,
   output logic             go,
   output logic             finish,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done,
   output logic             start_error,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             go_q, go_d;
   logic             finish_q, finish_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             start_error_q, start_error_d;

   logic             wr_en;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;

   range_sample_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (count_q[AW-1:0]),
      .wr_data (load_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // start wins over a simultaneous load, so it also masks load_ready.
   assign load_ready = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !start;

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      go_d          = 1'b0;
      finish_d      = 1'b0;
      data_d        = '0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      start_error_d = 1'b0;
      wr_en         = 1'b0;
      rd_addr       = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               // A one-sample transaction would need go and finish together.
               if (count_q < CW'(2)) begin
                  start_error_d = 1'b1;
               end else begin
                  state_d  = STREAM;
                  go_d     = 1'b1;
                  busy_d   = 1'b1;
                  data_d   = rd_data;
                  rd_ptr_d = CW'(1);
               end
            end else if (load_valid && load_ready) begin
               wr_en   = 1'b1;
               count_d = count_q + CW'(1);
            end
         end
         STREAM: begin
            if (finish_q) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               rd_addr  = rd_ptr_q[AW-1:0];
               data_d   = rd_data;
               busy_d   = 1'b1;
               finish_d = (rd_ptr_q == count_q - CW'(1)) || abort;
               rd_ptr_d = rd_ptr_q + CW'(1);
            end
         end
         DONE: begin
            state_d  = IDLE;
            count_d  = '0;
            rd_ptr_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         go_q          <= 1'b0;
         finish_q      <= 1'b0;
         data_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         start_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         go_q          <= go_d;
         finish_q      <= finish_d;
         data_q        <= data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         start_error_q <= start_error_d;
      end
   end

   assign go          = go_q;
   assign finish      = finish_q;
   assign data_out    = data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign start_error = start_error_q;
   assign count       = count_q;

endmodule

// File: tb/tb_range_streamer.sv
// Scoreboard bench for range_streamer: expected beats are queued at start
// and popped as the streamer emits them.
module tb_range_streamer;

   logic        clock;
   logic        reset;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic        start;
   logic        abort;
   logic        go;
   logic        finish;
   logic [15:0] data_out;
   logic        busy;
   logic        done;
   logic        start_error;
   logic [3:0]  count;

   typedef struct {
      logic [15:0] d;
      logic        g;
      logic        f;
   } beat_t;

   beat_t       exp_q[$];
   logic [15:0] model_buf[$];
   int          n_cmp;
   int          n_bad;

   range_streamer #(.WIDTH(16), .DEPTH(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .start       (start),
      .abort       (abort),
      .go          (go),
      .finish      (finish),
      .data_out    (data_out),
      .busy        (busy),
      .done        (done),
      .start_error (start_error),
      .count       (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      load_valid = 1'b0;
      load_data  = '0;
      start      = 1'b0;
      abort      = 1'b0;
      reset      = 1'b0;
      repeat (2) @(posedge clock);
      #3;
      reset = 1'b1;
      tick();
      model_buf.delete();
      exp_q.delete();
   endtask

   task automatic load_sample(input logic [15:0] d);
      load_valid = 1'b1;
      load_data  = d;
      #1;
      n_cmp++;
      if (load_ready !== (model_buf.size() < 8)) begin
         n_bad++;
         $display("FAIL load_ready: got %b, required %b", load_ready, model_buf.size() < 8);
      end
      tick();
      load_valid = 1'b0;
      if (model_buf.size() < 8) model_buf.push_back(d);
   endtask

   // Queues the expected beats, starts the stream and scores it beat by beat.
   task automatic drive_and_score_stream(input string name, input int abort_at);
      int n_beats;
      n_beats = model_buf.size();
      if (abort_at >= 0 && abort_at + 2 < n_beats) n_beats = abort_at + 2;
      for (int i = 0; i < n_beats; i++) begin
         beat_t b;
         b.d = model_buf[i];
         b.g = (i == 0);
         b.f = (i == n_beats - 1);
         exp_q.push_back(b);
      end
      start = 1'b1;
      tick();
      start      = 1'b0;
      load_valid = 1'b0;
      for (int beat = 0; exp_q.size() > 0; beat++) begin
         beat_t e;
         e = exp_q.pop_front();
         n_cmp++;
         if (busy !== 1'b1 || go !== e.g || finish !== e.f || data_out !== e.d) begin
            n_bad++;
            $display("FAIL %s beat %0d: got busy=%b go=%b finish=%b data=%h, required busy=1 go=%b finish=%b data=%h",
                     name, beat, busy, go, finish, data_out, e.g, e.f, e.d);
         end
         if (beat == abort_at) abort = 1'b1;
         tick();
         abort = 1'b0;
      end
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || go !== 1'b0 || finish !== 1'b0 || data_out !== 16'h0) begin
         n_bad++;
         $display("FAIL %s done_beat: got done=%b busy=%b go=%b finish=%b data=%h, required done=1 others 0",
                  name, done, busy, go, finish, data_out);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || count !== 4'd0 || load_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s back_to_idle: got done=%b count=%0d load_ready=%b, required 0/0/1",
                  name, done, count, load_ready);
      end
      $display("stream %s: %0d beats scored", name, n_beats);
      model_buf.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (go !== 1'b0 || finish !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          start_error !== 1'b0 || data_out !== 16'h0 || count !== 4'd0 || load_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_state: got go=%b finish=%b busy=%b done=%b serr=%b data=%h count=%0d ready=%b, required all 0 and ready=1",
                  go, finish, busy, done, start_error, data_out, count, load_ready);
      end
      $display("reset: outputs checked");
   endtask

   task automatic test_basic();
      load_sample(16'h0305);
      load_sample(16'h0310);
      load_sample(16'h0301);
      n_cmp++;
      if (count !== 4'd3) begin
         n_bad++;
         $display("FAIL basic_count: got %0d, required 3", count);
      end
      drive_and_score_stream("basic", -1);
   endtask

   task automatic test_start_error();
      load_sample(16'h1111);
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (start_error !== 1'b1 || go !== 1'b0 || busy !== 1'b0 || count !== 4'd1) begin
         n_bad++;
         $display("FAIL start_error_pulse: got serr=%b go=%b busy=%b count=%0d, required 1/0/0/1",
                  start_error, go, busy, count);
      end
      tick();
      n_cmp++;
      if (start_error !== 1'b0 || go !== 1'b0 || count !== 4'd1) begin
         n_bad++;
         $display("FAIL start_error_clear: got serr=%b go=%b count=%0d, required 0/0/1",
                  start_error, go, count);
      end
      $display("start_error: rejected start checked");
      do_reset();
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) load_sample(16'h0200 + 16'(i));
      #1;
      n_cmp++;
      if (load_ready !== 1'b0 || count !== 4'd8) begin
         n_bad++;
         $display("FAIL full_state: got ready=%b count=%0d, required 0/8", load_ready, count);
      end
      load_valid = 1'b1;
      load_data  = 16'hBEEF;
      tick();
      load_valid = 1'b0;
      n_cmp++;
      if (count !== 4'd8) begin
         n_bad++;
         $display("FAIL full_ninth_load: got count=%0d, required 8", count);
      end
      drive_and_score_stream("full", -1);
   endtask

   task automatic test_abort();
      for (int i = 0; i < 8; i++) load_sample(16'h0300 + 16'(i));
      drive_and_score_stream("abort", 1);
   endtask

   task automatic test_back_to_back_start_load();
      load_sample(16'h0A01);
      load_sample(16'h0A02);
      load_valid = 1'b1;
      load_data  = 16'hDEAD;
      start      = 1'b1;
      #1;
      n_cmp++;
      if (load_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL start_masks_ready: got %b, required 0", load_ready);
      end
      drive_and_score_stream("start_vs_load", -1);
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 5; i++) load_sample(16'h0300 + 16'(i));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (data_out !== 16'h0302 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midstream_beat2: got data=%h busy=%b, required 0302/1", data_out, busy);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (go !== 1'b0 || finish !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0) begin
         n_bad++;
         $display("FAIL async_reset_clear: got go=%b finish=%b busy=%b data=%h, required all 0",
                  go, finish, busy, data_out);
      end
      #3;
      reset = 1'b1;
      tick();
      n_cmp++;
      if (count !== 4'd0 || load_ready !== 1'b1 || busy !== 1'b0 || finish !== 1'b0) begin
         n_bad++;
         $display("FAIL after_reset_release: got count=%0d ready=%b busy=%b finish=%b, required 0/1/0/0",
                  count, load_ready, busy, finish);
      end
      model_buf.delete();
      exp_q.delete();
      $display("reset_midstream: asynchronous clear checked");
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      start      = 1'b0;
      abort      = 1'b0;
      test_reset();
      test_basic();
      test_start_error();
      test_full();
      test_abort();
      test_back_to_back_start_load();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
